// File: rtl/sprite_blitter_if.sv
// Pixel-stream and framebuffer-write bundle for sprite_blitter.
// The master side is the loader/framebuffer environment, the slave side is the blitter.
interface sprite_blitter_if #(
  parameter int DATA_WIDTH    = 12,
  parameter int X_WIDTH       = 5,
  parameter int Y_WIDTH       = 5,
  parameter int TILE_BITS     = 5,
  parameter int FB_ADDR_WIDTH = 19
);
  logic                     in_valid;
  logic [2*TILE_BITS-1:0]   in_addr;
  logic [DATA_WIDTH-1:0]    in_data;
  logic [X_WIDTH-1:0]       tile_x;
  logic [Y_WIDTH-1:0]       tile_y;
  logic                     fb_we;
  logic [FB_ADDR_WIDTH-1:0] fb_addr;
  logic [DATA_WIDTH-1:0]    fb_data;
  logic                     fb_ready;

  modport master (
    output in_valid, in_addr, in_data, tile_x, tile_y, fb_ready,
    input  fb_we, fb_addr, fb_data
  );

  modport slave (
    input  in_valid, in_addr, in_data, tile_x, tile_y, fb_ready,
    output fb_we, fb_addr, fb_data
  );
endinterface

// File: rtl/sprite_blitter.sv
// sprite_blitter: turns the loader's per-pixel tile stream into clipped absolute
// framebuffer writes, buffered in a small FIFO and drained under fb_ready.
// Optional colour keying is enabled by defining SPRITE_BLITTER_TRANSPARENT_KEY_EN.
module sprite_blitter #(
  parameter int                    DATA_WIDTH        = 12,
  parameter int                    X_WIDTH           = 5,
  parameter int                    Y_WIDTH           = 5,
  parameter int                    TILE_BITS         = 5,
  parameter int                    SCREEN_WIDTH      = 640,
  parameter int                    SCREEN_HEIGHT     = 480,
  parameter int                    FB_ADDR_WIDTH     = 19,
  parameter int                    FIFO_DEPTH        = 4,
  parameter logic [DATA_WIDTH-1:0] TRANSPARENT_COLOR = 12'hF0F
) (
  input  logic             clock,
  input  logic             reset_n,
  sprite_blitter_if.slave  bus,
  output logic             sprite_done,
  output logic             overflow,
  output logic             busy
);

  localparam int AX_W  = X_WIDTH + TILE_BITS;
  localparam int AY_W  = Y_WIDTH + TILE_BITS;
  localparam int PIX_W = 2 * TILE_BITS;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] SCREEN_W_U = 32'(SCREEN_WIDTH);
  localparam logic [31:0] SCREEN_H_U = 32'(SCREEN_HEIGHT);

`ifdef SPRITE_BLITTER_TRANSPARENT_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  // Stage 1 registers: absolute pixel coordinates, colour and end-of-sprite marker.
  logic                  s1_valid_r;
  logic [AX_W-1:0]       s1_ax_r;
  logic [AY_W-1:0]       s1_ay_r;
  logic [DATA_WIDTH-1:0] s1_data_r;
  logic                  s1_last_r;

  // Stage 2 results, computed from stage 1 and written straight into the FIFO.
  logic [FB_ADDR_WIDTH-1:0] s2_addr_s;
  logic                     s2_wr_s;

  // FIFO storage and control.
  logic [FB_ADDR_WIDTH-1:0] fifo_addr_r [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    fifo_data_r [FIFO_DEPTH];
  logic                     fifo_wr_r   [FIFO_DEPTH];
  logic                     fifo_last_r [FIFO_DEPTH];
  logic [PTR_W-1:0]         rd_ptr_r;
  logic [PTR_W-1:0]         wr_ptr_r;
  logic [CNT_W-1:0]         count_r;

  logic empty_s;
  logic full_s;
  logic head_wr_s;
  logic head_last_s;
  logic pop_s;
  logic push_s;
  logic drop_s;

  logic sprite_done_r;
  logic overflow_r;

  // Stage 1: concatenating tile and pixel coordinates is tile*2^TILE_BITS + offset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      s1_ax_r    <= '0;
      s1_ay_r    <= '0;
      s1_data_r  <= '0;
      s1_last_r  <= 1'b0;
    end else begin
      s1_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        s1_ax_r   <= {bus.tile_x, bus.in_addr[TILE_BITS-1:0]};
        s1_ay_r   <= {bus.tile_y, bus.in_addr[PIX_W-1:TILE_BITS]};
        s1_data_r <= bus.in_data;
        s1_last_r <= &bus.in_addr;
      end
    end
  end

  // Stage 2: linear address, on-screen clip test and optional colour key.
  always_comb begin
    s2_addr_s = FB_ADDR_WIDTH'(32'(s1_ay_r) * SCREEN_W_U + 32'(s1_ax_r));
    s2_wr_s   = (32'(s1_ax_r) < SCREEN_W_U) && (32'(s1_ay_r) < SCREEN_H_U) &&
                !(KEY_EN && (s1_data_r == TRANSPARENT_COLOR));
  end

  // FIFO status and handshake; clipped heads retire without waiting for fb_ready.
  always_comb begin
    empty_s     = (count_r == CNT_W'(0));
    full_s      = (count_r == CNT_W'(FIFO_DEPTH));
    head_wr_s   = fifo_wr_r[rd_ptr_r];
    head_last_s = fifo_last_r[rd_ptr_r];
    pop_s       = !empty_s && (!head_wr_s || bus.fb_ready);
    push_s      = s1_valid_r && (!full_s || pop_s);
    drop_s      = s1_valid_r && full_s && !pop_s;
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_r[i] <= '0;
        fifo_data_r[i] <= '0;
        fifo_wr_r[i]   <= 1'b0;
        fifo_last_r[i] <= 1'b0;
      end
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        fifo_addr_r[wr_ptr_r] <= s2_addr_s;
        fifo_data_r[wr_ptr_r] <= s1_data_r;
        fifo_wr_r[wr_ptr_r]   <= s2_wr_s;
        fifo_last_r[wr_ptr_r] <= s1_last_r;
        wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Status flags: sprite completion pulse and sticky overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sprite_done_r <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      sprite_done_r <= pop_s && head_last_s;
      overflow_r    <= overflow_r | drop_s;
    end
  end

  // Stage 2 has no register of its own, so stage 1 valid also covers it in busy.
  assign bus.fb_we   = !empty_s && head_wr_s;
  assign bus.fb_addr = fifo_addr_r[rd_ptr_r];
  assign bus.fb_data = fifo_data_r[rd_ptr_r];
  assign sprite_done = sprite_done_r;
  assign overflow    = overflow_r;
  assign busy        = s1_valid_r | !empty_s;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: stimulus pushes model-predicted writes,
// a negedge monitor retires them against the framebuffer handshake.
module tb_sprite_blitter;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic sprite_done;
  logic overflow;
  logic busy;

  sprite_blitter_if #(
    .DATA_WIDTH(12), .X_WIDTH(5), .Y_WIDTH(5), .TILE_BITS(5), .FB_ADDR_WIDTH(19)
  ) bus ();

  sprite_blitter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .sprite_done (sprite_done),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   writes = 0;
  int   dones = 0;
  int   exp_dones = 0;
  bit   rand_ready = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: where a tile pixel lands on screen and whether it is written.
  function automatic bit visible(input int tx, input int ty, input int px,
                                 input int py, input int col, output int addr);
    int ax;
    int ay;
    bit vis;
    ax   = tx * 32 + px;
    ay   = ty * 32 + py;
    addr = (ay * 640 + ax) % (1 << 19);
    vis  = (ax < 640) && (ay < 480);
`ifdef SPRITE_BLITTER_TRANSPARENT_KEY_EN
    if (col == 'hF0F) vis = 1'b0;
`endif
    return vis;
  endfunction

  task automatic send_pixel(input int tx, input int ty, input int px, input int py,
                            input int col, input bit keep);
    int a;
    @(posedge clock);
    #1;
    if (rand_ready) bus.fb_ready = 1'($urandom_range(0, 1));
    bus.in_valid = 1'b1;
    bus.tile_x   = 5'(tx);
    bus.tile_y   = 5'(ty);
    bus.in_addr  = 10'(py * 32 + px);
    bus.in_data  = 12'(col);
    if (keep) begin
      if (visible(tx, ty, px, py, col, a)) exp_q.push_back('{addr: a, data: col});
      if (px == 31 && py == 31) exp_dones++;
    end
  endtask

  task automatic idle();
    @(posedge clock);
    #1;
    if (rand_ready) bus.fb_ready = 1'($urandom_range(0, 1));
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      idle();
      n++;
    end while (busy && n < 3000);
    check({name, "_drain_busy"}, int'(busy), 0);
    repeat (2) idle();
    check({name, "_queue_left"}, exp_q.size(), 0);
    check({name, "_sprite_done"}, dones, exp_dones);
  endtask

  task automatic full_sprite(input int tx, input int ty);
    for (int py = 0; py < 32; py++)
      for (int px = 0; px < 32; px++)
        send_pixel(tx, ty, px, py, int'($urandom_range(0, 4095)), 1'b1);
  endtask

  // Monitor: retire writes in order and check hold-stable under backpressure.
  logic        prev_stall = 1'b0;
  logic [18:0] prev_addr = '0;
  logic [11:0] prev_data = '0;
  always @(negedge clock) begin
    exp_t e;
    if (reset_n) begin
      if (prev_stall) begin
        check("hold_we", int'(bus.fb_we), 1);
        check("hold_addr", int'(bus.fb_addr), int'(prev_addr));
        check("hold_data", int'(bus.fb_data), int'(prev_data));
      end
      if (bus.fb_we && bus.fb_ready) begin
        writes++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %0h, expected no write",
                   bus.fb_addr, bus.fb_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", int'(bus.fb_addr), e.addr);
          check("wr_data", int'(bus.fb_data), e.data);
        end
      end
      if (sprite_done) dones++;
      prev_stall = bus.fb_we && !bus.fb_ready;
      prev_addr  = bus.fb_addr;
      prev_data  = bus.fb_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic origin_test(input string name);
    send_pixel(0, 0, 0, 0, 'hABC, 1'b1);
    idle();
    check({name, "_we_early"}, int'(bus.fb_we), 0);
    @(posedge clock);
    #1;
    check({name, "_we"}, int'(bus.fb_we), 1);
    check({name, "_addr"}, int'(bus.fb_addr), 0);
    check({name, "_data"}, int'(bus.fb_data), 'hABC);
    @(posedge clock);
    #1;
    check({name, "_busy_fall"}, int'(busy), 0);
    wait_idle(name);
  endtask

  initial begin
    int w0;
    int n;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    bus.tile_x   = '0;
    bus.tile_y   = '0;
    bus.fb_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_fb_we", int'(bus.fb_we), 0);
    check("rst_fb_addr", int'(bus.fb_addr), 0);
    check("rst_fb_data", int'(bus.fb_data), 0);
    check("rst_sprite_done", int'(sprite_done), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_busy", int'(busy), 0);
    reset_n = 1'b1;

    origin_test("origin");

    send_pixel(1, 2, 3, 4, 'h123, 1'b1);
    wait_idle("addr_arith");

    w0 = writes;
    full_sprite(3, 3);
    wait_idle("full_sprite");
    check("full_sprite_writes", writes - w0, 1024);
    check("full_sprite_overflow", int'(overflow), 0);

    w0 = writes;
    full_sprite(20, 0);
    wait_idle("clip_x");
    check("clip_x_writes", writes - w0, 0);

    w0 = writes;
    full_sprite(0, 14);
    wait_idle("clip_y14");
    check("clip_y14_writes", writes - w0, 1024);

    w0 = writes;
    for (int i = 0; i < 64; i++) send_pixel(0, 15, i % 32, i / 32, 'h555, 1'b1);
    wait_idle("clip_y15");
    check("clip_y15_writes", writes - w0, 0);

    for (int i = 0; i < 16; i++)
      send_pixel(5, 5, i, 0, (i % 2 == 0) ? 'hF0F : int'($urandom_range(0, 4095)), 1'b1);
    wait_idle("keyed");

    rand_ready = 1'b1;
    for (int b = 0; b < 40; b++) begin
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 7) == 0)
          send_pixel(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 31, 31,
                     int'($urandom_range(0, 4095)), 1'b1);
        else
          send_pixel(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 4095)), 1'b1);
      end
      repeat (int'($urandom_range(0, 3))) idle();
      wait_idle("random");
    end
    rand_ready = 1'b0;
    bus.fb_ready = 1'b1;
    check("random_overflow", int'(overflow), 0);

    bus.fb_ready = 1'b0;
    w0 = writes;
    for (int i = 0; i < 10; i++) send_pixel(0, 0, i, 0, 'h100 + i, i < 4);
    repeat (4) idle();
    check("bp_overflow", int'(overflow), 1);
    check("bp_we", int'(bus.fb_we), 1);
    check("bp_addr", int'(bus.fb_addr), 0);
    check("bp_data", int'(bus.fb_data), 'h100);
    check("bp_busy", int'(busy), 1);
    check("bp_no_writes", writes - w0, 0);
    bus.fb_ready = 1'b1;
    wait_idle("backpressure");
    check("bp_writes", writes - w0, 4);

    for (int i = 0; i < 100; i++)
      send_pixel(2, 2, i % 32, i / 32, int'($urandom_range(0, 4095)), 1'b1);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_fb_we", int'(bus.fb_we), 0);
    check("mid_rst_fb_addr", int'(bus.fb_addr), 0);
    check("mid_rst_fb_data", int'(bus.fb_data), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_sprite_done", int'(sprite_done), 0);
    check("mid_rst_overflow", int'(overflow), 0);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    check("mid_rst_dones", dones, exp_dones);
    origin_test("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Sits directly downstream of the sprite loader.
- Consumes the loader's per-pixel stream: enable, pixel index within the tile, 12-bit colour, and tile coordinates.
- Converts each pixel to an absolute framebuffer address, clips pixels that fall off screen, and buffers writes in a small FIFO.
- Drains the FIFO into the framebuffer write port under an fb_ready handshake and signals when a full sprite has been committed.

Parameters:
- DATA_WIDTH, 12, pixel colour width.
- X_WIDTH, 5, tile x coordinate width.
- Y_WIDTH, 5, tile y coordinate width.
- TILE_BITS, 5, log2 of tile edge in pixels (32x32 tile); pixel index width is 2*TILE_BITS.
- SCREEN_WIDTH, 640, visible pixels per row.
- SCREEN_HEIGHT, 480, visible rows.
- FB_ADDR_WIDTH, 19, framebuffer address width.
- FIFO_DEPTH, 4, write buffer entries (power of two).
- TRANSPARENT_COLOR, 12'hF0F, colour key (used only with the optional feature).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  pixel strobe from the loader's load_enable.
- in_addr  in  2*TILE_BITS  pixel index within the tile; [TILE_BITS-1:0]=px, upper bits=py.
- in_data  in  DATA_WIDTH  pixel colour.
- tile_x  in  X_WIDTH  tile column.
- tile_y  in  Y_WIDTH  tile row.
- fb_we  out  1  framebuffer write request.
- fb_addr  out  FB_ADDR_WIDTH  framebuffer word address.
- fb_data  out  DATA_WIDTH  framebuffer write data.
- fb_ready  in  1  framebuffer accepts the write this cycle.
- sprite_done  out  1  one-cycle pulse when the last pixel of a sprite retires.
- overflow  out  1  sticky flag: a pixel was dropped because the FIFO was full.
- busy  out  1  high while the pipeline or the FIFO holds any entry.

Behaviour:
- Reset: asynchronous on reset_n low; on release all of the following hold.
  - fb_we=0, fb_addr=0, fb_data=0.
  - sprite_done=0, overflow=0, busy=0.
  - FIFO empty; pipeline valid bits cleared.
  - Asserting reset mid-sprite discards every in-flight pixel with no sprite_done.
- Stage 1, on the edge where in_valid=1:
  - Register ax = tile_x*2^TILE_BITS + px and ay = tile_y*2^TILE_BITS + py.
  - Each is X_WIDTH+TILE_BITS / Y_WIDTH+TILE_BITS bits, zero-extended, no overflow possible.
  - Also register the colour and last = (in_addr is all ones).
- Stage 2, one edge later:
  - Compute addr = ay*SCREEN_WIDTH + ax, truncated to FB_ADDR_WIDTH.
  - Compute wr = (ax < SCREEN_WIDTH) && (ay < SCREEN_HEIGHT).
  - Push {addr, colour, wr, last} into the FIFO.
- Output: fb_addr and fb_data come from the FIFO head; fb_we = !empty && head.wr.
- Pop rules:
  - Head pops when fb_we && fb_ready.
  - Head also pops unconditionally when head.wr=0; fb_we stays 0 and nothing is written.
- Latency: with an empty FIFO, a pixel sampled at edge N presents fb_we in the cycle after edge N+1. Throughput is one pixel per clock while fb_ready=1.
- fb_addr and fb_data hold stable while fb_we=1 and fb_ready=0.
- Full FIFO:
  - If a push occurs while full and no pop happens that cycle, the pixel is dropped and overflow sets; overflow stays set until reset.
  - Push and pop in the same cycle while full is legal, and nothing is dropped.
- Empty FIFO: fb_we=0. Pop requests are ignored.
- sprite_done pulses exactly one cycle, registered, following the edge on which an entry with last=1 pops.
  - It pulses even if that pixel was clipped.
  - It does not pulse if that pixel was dropped on overflow.
- busy = stage1 valid | stage2 valid | !empty.
- Pixels do not need contiguous in_valid; gaps are allowed. Tile coordinates are sampled per pixel.

Optional Feature:
- Macro: SPRITE_BLITTER_TRANSPARENT_KEY_EN.
- Defined: a pixel whose colour equals TRANSPARENT_COLOR gets wr=0. It still traverses the FIFO and can carry last/sprite_done, but is never written.
- Undefined: every on-screen pixel is written regardless of colour; TRANSPARENT_COLOR is unused.

Test Plan:
- Single write at origin: tile (0,0), in_addr=0, in_data=12'hABC, fb_ready=1. Expect fb_we=1 with fb_addr=0 and fb_data=12'hABC in the cycle after the second edge; busy falls afterwards.
- Address arithmetic: tile (1,2), px=3, py=4 → ax=35, ay=68. Expect fb_addr=68*640+35=43555.
- Full sprite: 1024 consecutive pixels at tile (3,3), fb_ready=1. Expect exactly 1024 fb_we cycles with ascending correct addresses, one sprite_done after the last write, and overflow=0.
- Backpressure: stream 10 pixels with fb_ready=0. Expect the FIFO to hold 4 entries with fb_addr/fb_data stable and overflow=1. Then raise fb_ready and expect exactly 4 writes.
- Clipping: tile_x=20 (ax≥640), full sprite. Expect zero fb_we and still one sprite_done. Tile (0,14) rows ay≥480: only rows py<32 with ay<480 are written.
- Reset mid-sprite: assert reset_n=0 after 100 pixels. Expect all outputs zero immediately, no sprite_done, and a subsequent single-pixel write behaving as in the first test.
- With SPRITE_BLITTER_TRANSPARENT_KEY_EN defined: pixels of colour 12'hF0F produce no fb_we; other colours are written.
